// File: rtl/debounce_edge_detect.sv
// Debounced edge detector: synchronizes a raw asynchronous input, accepts a level
// change only after STABLE_CYCLES steady samples, and counts accepted edges and glitches.
module debounce_edge_detect #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             inClk,
   input  logic             inRstN,
   input  logic             inD,
   input  logic             inClr,
   output logic             outQ,
   output logic             outRise,
   output logic             outFall,
   output logic             outBusy,
   output logic [CNT_W-1:0] outEdgeCnt,
   output logic [CNT_W-1:0] outGlitchCnt
);

   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW    = 2'd0,
      WAIT_H = 2'd1,
      HIGH   = 2'd2,
      WAIT_L = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   q_q, q_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]       glitch_cnt_q, glitch_cnt_d;
   logic                   sync_s;
   logic                   edge_inc;
   logic                   glitch_inc;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], inD};
      sync_s     = sync_q[SYNC_STAGES-1];
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_d        = q_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      edge_inc   = 1'b0;
      glitch_inc = 1'b0;

      case (state_q)
         LOW: begin
            q_d = 1'b0;
            if (sync_s) begin
               state_d = WAIT_H;
               cnt_d   = CW'(1);
            end
         end
         WAIT_H: begin
            if (!sync_s) begin
               state_d    = LOW;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = HIGH;
               cnt_d    = '0;
               q_d      = 1'b1;
               rise_d   = 1'b1;
               edge_inc = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HIGH: begin
            q_d = 1'b1;
            if (!sync_s) begin
               state_d = WAIT_L;
               cnt_d   = CW'(1);
            end
         end
         WAIT_L: begin
            if (sync_s) begin
               state_d    = HIGH;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = LOW;
               cnt_d    = '0;
               q_d      = 1'b0;
               fall_d   = 1'b1;
               edge_inc = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
            q_d     = 1'b0;
         end
      endcase

      busy_d = (state_d == WAIT_H) || (state_d == WAIT_L);

      // Clear has priority over a coincident increment; both counters saturate.
      edge_cnt_d   = edge_cnt_q;
      glitch_cnt_d = glitch_cnt_q;
      if (inClr) begin
         edge_cnt_d   = '0;
         glitch_cnt_d = '0;
      end else begin
         if (edge_inc && (edge_cnt_q != '1))
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
         if (glitch_inc && (glitch_cnt_q != '1))
            glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         sync_q       <= '0;
         state_q      <= LOW;
         cnt_q        <= '0;
         q_q          <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         busy_q       <= 1'b0;
         edge_cnt_q   <= '0;
         glitch_cnt_q <= '0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         q_q          <= q_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         busy_q       <= busy_d;
         edge_cnt_q   <= edge_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign outQ         = q_q;
   assign outRise      = rise_q;
   assign outFall      = fall_q;
   assign outBusy      = busy_q;
   assign outEdgeCnt   = edge_cnt_q;
   assign outGlitchCnt = glitch_cnt_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect: default, narrow-counter and
// deeper-synchronizer configurations driven from one linear sequence.
module tb_debounce_edge_detect;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   // a: defaults
   logic       rst_a, d_a, clr_a, q_a, rise_a, fall_a, busy_a;
   logic [7:0] ecnt_a, gcnt_a;
   // b: CNT_W=2
   logic       rst_b, d_b, clr_b, q_b, rise_b, fall_b, busy_b;
   logic [1:0] ecnt_b, gcnt_b;
   // c: SYNC_STAGES=3, STABLE_CYCLES=2
   logic       rst_c, d_c, clr_c, q_c, rise_c, fall_c, busy_c;
   logic [7:0] ecnt_c, gcnt_c;

   int tests = 0;
   int fails = 0;

   debounce_edge_detect u_a (
      .inClk(clk), .inRstN(rst_a), .inD(d_a), .inClr(clr_a),
      .outQ(q_a), .outRise(rise_a), .outFall(fall_a), .outBusy(busy_a),
      .outEdgeCnt(ecnt_a), .outGlitchCnt(gcnt_a)
   );

   debounce_edge_detect #(.CNT_W(2)) u_b (
      .inClk(clk), .inRstN(rst_b), .inD(d_b), .inClr(clr_b),
      .outQ(q_b), .outRise(rise_b), .outFall(fall_b), .outBusy(busy_b),
      .outEdgeCnt(ecnt_b), .outGlitchCnt(gcnt_b)
   );

   debounce_edge_detect #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) u_c (
      .inClk(clk), .inRstN(rst_c), .inD(d_c), .inClr(clr_c),
      .outQ(q_c), .outRise(rise_c), .outFall(fall_c), .outBusy(busy_c),
      .outEdgeCnt(ecnt_c), .outGlitchCnt(gcnt_c)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_a = 1'b0; d_a = 1'b0; clr_a = 1'b0;
      rst_b = 1'b0; d_b = 1'b0; clr_b = 1'b0;
      rst_c = 1'b0; d_c = 1'b0; clr_c = 1'b0;

      // Reset state
      tick; tick;
      chk("rst_q",    32'(q_a),    0);
      chk("rst_rise", 32'(rise_a), 0);
      chk("rst_fall", 32'(fall_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_ecnt", 32'(ecnt_a), 0);
      chk("rst_gcnt", 32'(gcnt_a), 0);
      chk("rst_b_ecnt", 32'(ecnt_b), 0);
      chk("rst_c_q",    32'(q_c),    0);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Idle low input
      for (int k = 1; k <= 10; k++) begin
         tick;
         chk("idle_q",    32'(q_a),    0);
         chk("idle_rise", 32'(rise_a), 0);
         chk("idle_fall", 32'(fall_a), 0);
         chk("idle_busy", 32'(busy_a), 0);
      end
      chk("idle_ecnt", 32'(ecnt_a), 0);
      chk("idle_gcnt", 32'(gcnt_a), 0);

      // Accepted rise at edge 6
      d_a = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk("rise_q",    32'(q_a),    (k >= 6) ? 1 : 0);
         chk("rise_rise", 32'(rise_a), (k == 6) ? 1 : 0);
         chk("rise_fall", 32'(fall_a), 0);
         chk("rise_busy", 32'(busy_a), (k >= 3 && k <= 5) ? 1 : 0);
         chk("rise_ecnt", 32'(ecnt_a), (k >= 6) ? 1 : 0);
      end
      // Accepted fall at edge 6
      d_a = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk("fall_q",    32'(q_a),    (k >= 6) ? 0 : 1);
         chk("fall_fall", 32'(fall_a), (k == 6) ? 1 : 0);
         chk("fall_rise", 32'(rise_a), 0);
         chk("fall_busy", 32'(busy_a), (k >= 3 && k <= 5) ? 1 : 0);
         chk("fall_ecnt", 32'(ecnt_a), (k >= 6) ? 2 : 1);
      end
      chk("fall_gcnt", 32'(gcnt_a), 0);

      // Clear counters
      clr_a = 1'b1;
      tick;
      chk("clr_ecnt", 32'(ecnt_a), 0);
      chk("clr_q",    32'(q_a),    0);
      clr_a = 1'b0;

      // Five short glitches
      for (int r = 0; r < 5; r++) begin
         d_a = 1'b1;
         for (int k = 0; k < 2; k++) begin
            tick;
            chk("gl_q",    32'(q_a),    0);
            chk("gl_rise", 32'(rise_a), 0);
         end
         d_a = 1'b0;
         for (int k = 0; k < 4; k++) begin
            tick;
            chk("gl_q",    32'(q_a),    0);
            chk("gl_rise", 32'(rise_a), 0);
            chk("gl_fall", 32'(fall_a), 0);
         end
      end
      chk("gl_gcnt", 32'(gcnt_a), 5);
      chk("gl_ecnt", 32'(ecnt_a), 0);
      chk("gl_busy", 32'(busy_a), 0);

      // Reset while in WAIT_H with cnt=2
      d_a = 1'b1;
      tick; tick; tick; tick;
      chk("mid_busy", 32'(busy_a), 1);
      rst_a = 1'b0;
      tick;
      chk("mid_rst_q",    32'(q_a),    0);
      chk("mid_rst_rise", 32'(rise_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_gcnt", 32'(gcnt_a), 0);
      rst_a = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick;
         chk("rel_q",    32'(q_a),    (k >= 6) ? 1 : 0);
         chk("rel_rise", 32'(rise_a), (k == 6) ? 1 : 0);
         chk("rel_ecnt", 32'(ecnt_a), (k >= 6) ? 1 : 0);
      end

      // Narrow counter saturation
      for (int r = 0; r < 4; r++) begin
         d_b = 1'b1;
         for (int k = 0; k < 8; k++) tick;
         chk("sat_q_hi", 32'(q_b), 1);
         d_b = 1'b0;
         for (int k = 0; k < 8; k++) tick;
         chk("sat_ecnt", 32'(ecnt_b), (2 * (r + 1) > 3) ? 3 : 2 * (r + 1));
      end
      chk("sat_q", 32'(q_b), 0);
      // Clear coinciding with an accepted rise
      d_b = 1'b1;
      for (int k = 0; k < 5; k++) tick;
      chk("pre_clr_ecnt", 32'(ecnt_b), 3);
      clr_b = 1'b1;
      tick;
      chk("clr_co_ecnt", 32'(ecnt_b), 0);
      chk("clr_co_rise", 32'(rise_b), 1);
      chk("clr_co_q",    32'(q_b),    1);
      clr_b = 1'b0;
      tick;
      chk("clr_after_rise", 32'(rise_b), 0);
      chk("clr_after_q",    32'(q_b),    1);
      chk("clr_after_ecnt", 32'(ecnt_b), 0);

      // Deeper synchronizer, shorter stability window
      d_c = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick;
         chk("s3_q",    32'(q_c),    (k >= 5) ? 1 : 0);
         chk("s3_rise", 32'(rise_c), (k == 5) ? 1 : 0);
      end
      chk("s3_ecnt", 32'(ecnt_c), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/debounce_edge_detect.md
Name: debounce_edge_detect

Overview:
- Downstream consumer of the edge-triggered D flip-flop stage.
- Takes a raw, possibly asynchronous and bouncy single-bit input and passes it through a SYNC_STAGES-deep flip-flop synchronizer chain.
- A debounce FSM accepts a level change only once the synchronized value has been stable for STABLE_CYCLES consecutive clocks.
- Outputs a clean level, one-cycle rise/fall pulses, and saturating counters of accepted edges and rejected glitches.

Parameters:
SYNC_STAGES, 2, depth of the input synchronizer chain; legal values are 2 and above.
STABLE_CYCLES, 4, consecutive synchronized samples required to accept a change; legal values are 2 and above.
CNT_W, 8, width of outEdgeCnt and outGlitchCnt.

Ports:
inClk  input  1  single clock; all flops update on its rising edge.
inRstN  input  1  reset; synchronous, active-low.
inD  input  1  raw data input; asynchronous to inClk.
inClr  input  1  synchronous clear of outEdgeCnt and outGlitchCnt.
outQ  output  1  debounced level.
outRise  output  1  one-cycle pulse on an accepted 0->1 change.
outFall  output  1  one-cycle pulse on an accepted 1->0 change.
outBusy  output  1  high while the FSM is in WAIT_H or WAIT_L.
outEdgeCnt  output  CNT_W  count of accepted edges (rise plus fall); saturates at all-ones.
outGlitchCnt  output  CNT_W  count of rejected candidate changes; saturates at all-ones.

Behaviour:
- Reset (inRstN=0 at a rising edge):
  - sync chain all 0, state=LOW, stability counter=0.
  - outQ, outRise, outFall, outBusy = 0; outEdgeCnt = outGlitchCnt = 0.
  - inClr has no effect during reset.
- Synchronizer: sync[0]<=inD, sync[i]<=sync[i-1]. s = sync[SYNC_STAGES-1] is the only signal the FSM reads.
- FSM states: LOW, WAIT_H, HIGH, WAIT_L. All outputs are registered.
  - LOW: outQ=0. If s=1, go to WAIT_H with cnt=1.
  - WAIT_H:
    - s=0: return to LOW, cnt=0, outGlitchCnt+1.
    - s=1 and cnt==STABLE_CYCLES-1: go to HIGH, outQ<=1, outRise<=1 for exactly one cycle, outEdgeCnt+1, cnt=0.
    - otherwise: cnt+1.
  - HIGH / WAIT_L: mirror image of LOW / WAIT_H with s inverted; the accepting transition produces outFall and outQ<=0.
- outBusy = (state==WAIT_H or state==WAIT_L), registered together with the state.
- Latency: number the edge that first captures the new inD into sync[0] as edge 1. outQ and the pulse update at edge SYNC_STAGES+STABLE_CYCLES. With defaults, that is edge 6.
- Glitch rule: a candidate change shorter than STABLE_CYCLES synchronized cycles never reaches outQ. Each aborted WAIT state counts as exactly one glitch.
- Pulse rules:
  - outRise and outFall are never high in the same cycle.
  - Neither is ever high for two consecutive cycles.
  - The first pulse cannot occur sooner than SYNC_STAGES+STABLE_CYCLES edges after reset release.
- Counters:
  - Increment by 1 and saturate; no wrap-around.
  - inClr=1 forces both to 0 on that edge. If inClr and an increment coincide, clear wins and the result is 0.
  - inClr does not affect the FSM, outQ or the pulses.
- Reset mid-operation: from any state, reset returns to LOW with no pulse and clears the sync chain. If inD is still high after release, the full latency applies again (outQ rises at edge SYNC_STAGES+STABLE_CYCLES after release capture).
- No combinational path from inD to any output.

Test Plan:
1. Defaults, 40 ns clock; hold reset 2 cycles, inD=0, inClr=0 for 10 cycles -> outQ=0, no pulses, outBusy=0, both counters 0.
2. inD 0->1 just before edge 1, held high -> outBusy=1 from edge 3; at edge 6 outQ=1, outRise=1 for one cycle, outBusy=0, outEdgeCnt=1; then inD->0 held -> outQ=0 and one outFall pulse 6 edges later, outEdgeCnt=2.
3. From LOW, inD high for 2 cycles then low; repeat 5 times, 4 low cycles apart -> outQ stays 0, no pulses, outEdgeCnt=0, outGlitchCnt=5.
4. CNT_W=2; 4 full accepted high/low pulses (8 edges) -> outEdgeCnt stops at 3; then inClr=1 coinciding with an accepted rise -> outEdgeCnt=0, outRise still pulses, outQ=1.
5. Assert reset at the cycle the FSM is in WAIT_H with cnt=2, inD held high -> after reset all outputs 0, no outRise during or after reset until edge 6 after release, then outRise once, outEdgeCnt=1.
6. SYNC_STAGES=3, STABLE_CYCLES=2; inD rises before edge 1 -> outQ=1 and outRise at edge 5, not at edge 4.
